// File: rtl/fm_pkg.sv
// ---------------------------------------------------------------------------
// fm_pkg
// Shared definitions for the multi-channel equal-precision frequency meter:
//   - fm_state_t    : per-channel measurement FSM states
//   - DEF_*         : default parameter values for the meter
//   - CNT_ALL_ONES  : all-ones counter value (sliced to CNT_W by users,
//                     so counters up to MAX_CNT_W bits are supported)
// ---------------------------------------------------------------------------
package fm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        STOP  = 2'd3
    } fm_state_t;

    localparam int DEF_CH_NUM      = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int                    MAX_CNT_W    = 64;
    localparam logic [MAX_CNT_W-1:0]  CNT_ALL_ONES = '1;

endpackage

// File: rtl/fm_channel.sv
// ---------------------------------------------------------------------------
// fm_channel
// One measurement channel: input synchroniser, rising-edge detector,
// measurement FSM, reference/signal counters and result registers.
//
// Optional feature macro: FM_OVF_SAT_EN
//   defined   : counters saturate; a saturated reference counter in COUNT or
//               STOP publishes all-ones counts with overflow=1 (lost-signal
//               timeout)
//   undefined : counters wrap, no timeout, overflow stays 0
//
// Ports:
//   sysClk, sysRst  clock / asynchronous active-high reset
//   tick_p          one-cycle gate-boundary pulse (already synchronised)
//   sig_in          raw asynchronous measured signal
//   enable          channel enable (sysClk domain)
//   ref_count       sysClk cycles spanning the last measurement
//   sig_count       whole signal periods of the last measurement
//   result_valid    one-cycle pulse when a result is published
//   overflow        overflow qualifier of the last result
// ---------------------------------------------------------------------------
module fm_channel
    import fm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             tick_p,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] ref_count,
    output logic [CNT_W-1:0] sig_count,
    output logic             result_valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] ALL_ONES = CNT_ALL_ONES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Counter increment: saturating when the overflow feature is built in,
    // plain modulo-2^CNT_W otherwise.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef FM_OVF_SAT_EN
        return (v == ALL_ONES) ? v : v + ONE;
`else
        return v + ONE;
`endif
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sig_prev_p1;
    logic                   edge_p;

    fm_state_t              state;
    logic [CNT_W-1:0]       ref_buf;
    logic [CNT_W-1:0]       sig_buf;
    logic                   ovf_q;
    logic                   timeout;

    // ---- stage p0: synchroniser; stage p1: registered rising-edge pulse ----
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            sync_p0     <= '0;
            sig_prev_p1 <= 1'b0;
            edge_p      <= 1'b0;
        end else begin
            sync_p0     <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            sig_prev_p1 <= sync_p0[SYNC_STAGES-1];
            edge_p      <= sync_p0[SYNC_STAGES-1] & ~sig_prev_p1;
        end
    end

`ifdef FM_OVF_SAT_EN
    assign timeout = (ref_buf == ALL_ONES);
`else
    assign timeout = 1'b0;
`endif

    // ---- measurement FSM, counters and result registers ----
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state        <= IDLE;
            ref_buf      <= '0;
            sig_buf      <= '0;
            ref_count    <= '0;
            sig_count    <= '0;
            result_valid <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            // Losing the enable abandons any measurement without a publish.
            if (state != IDLE && !enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick_p && enable)
                            state <= ARM;
                    end
                    ARM: begin
                        // Start edge: the reference count excludes this cycle.
                        if (edge_p) begin
                            state   <= COUNT;
                            ref_buf <= '0;
                            sig_buf <= '0;
                        end
                    end
                    COUNT: begin
                        if (timeout) begin
                            ref_count    <= ALL_ONES;
                            sig_count    <= ALL_ONES;
                            ovf_q        <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            ref_buf <= cnt_inc(ref_buf);
                            // An edge coincident with the closing tick is
                            // still a whole period inside the gate.
                            if (edge_p)
                                sig_buf <= cnt_inc(sig_buf);
                            if (tick_p)
                                state <= STOP;
                        end
                    end
                    STOP: begin
                        if (timeout) begin
                            ref_count    <= ALL_ONES;
                            sig_count    <= ALL_ONES;
                            ovf_q        <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= IDLE;
                        end else if (edge_p) begin
                            // The stop edge closes the last period and its
                            // cycle is included in the reference count.
                            ref_count    <= cnt_inc(ref_buf);
                            sig_count    <= cnt_inc(sig_buf);
                            ovf_q        <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            ref_buf <= cnt_inc(ref_buf);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign overflow = ovf_q;

endmodule

// File: rtl/multi_channel_freq_meter.sv
// ---------------------------------------------------------------------------
// multi_channel_freq_meter
// Multi-channel equal-precision frequency meter. A shared real-time gate tick
// opens and closes each channel's gate, aligned to that channel's own signal
// edges, so every result spans a whole number of signal periods.
// Frequency = sigCount * f_sysClk / refCount (computed downstream).
//
// Optional feature macro: FM_OVF_SAT_EN (saturating counters, lost-signal
// timeout and overflow flag; see fm_channel).
//
// Ports:
//   sysClk       system/reference clock
//   sysRst       asynchronous active-high reset
//   gateTick     asynchronous gate tick, rising edge = gate boundary
//   sigIn        CH_NUM asynchronous measured signals
//   chEnable     CH_NUM per-channel enables (sysClk domain)
//   refCount     CH_NUM*CNT_W packed reference counts, ch n at [n*CNT_W +: CNT_W]
//   sigCount     CH_NUM*CNT_W packed signal-period counts, same packing
//   resultValid  CH_NUM one-cycle publish pulses
//   overflow     CH_NUM overflow qualifiers of the last results
// ---------------------------------------------------------------------------
module multi_channel_freq_meter
    import fm_pkg::*;
#(
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    sysClk,
    input  logic                    sysRst,
    input  logic                    gateTick,
    input  logic [CH_NUM-1:0]       sigIn,
    input  logic [CH_NUM-1:0]       chEnable,
    output logic [CH_NUM*CNT_W-1:0] refCount,
    output logic [CH_NUM*CNT_W-1:0] sigCount,
    output logic [CH_NUM-1:0]       resultValid,
    output logic [CH_NUM-1:0]       overflow
);

    logic [SYNC_STAGES-1:0] tick_sync_p0;
    logic                   tick_prev_p1;
    logic                   tick_p;

    // ---- stage p0: gate tick synchroniser; stage p1: registered edge pulse ----
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            tick_sync_p0 <= '0;
            tick_prev_p1 <= 1'b0;
            tick_p       <= 1'b0;
        end else begin
            tick_sync_p0 <= {tick_sync_p0[SYNC_STAGES-2:0], gateTick};
            tick_prev_p1 <= tick_sync_p0[SYNC_STAGES-1];
            tick_p       <= tick_sync_p0[SYNC_STAGES-1] & ~tick_prev_p1;
        end
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        fm_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .sysClk       (sysClk),
            .sysRst       (sysRst),
            .tick_p       (tick_p),
            .sig_in       (sigIn[n]),
            .enable       (chEnable[n]),
            .ref_count    (refCount[n*CNT_W +: CNT_W]),
            .sig_count    (sigCount[n*CNT_W +: CNT_W]),
            .result_valid (resultValid[n]),
            .overflow     (overflow[n])
        );
    end

endmodule
